spec_ras: RTL and testbench

SPEC_RAS -- requirements
Module: spec_ras

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/ras_ckpt_queue.sv | 92 +++++++++
 rtl/spec_ras.sv | 125 ++++++++++++
 tb/tb_spec_ras.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared return-address-stack constants and checkpoint record
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN          = 32;
  localparam int RAS_SIZE      = 8;
  localparam int RAS_PTR_WIDTH = $clog2(RAS_SIZE);
  localparam int RAS_NUM_CKPT  = 4;

  typedef struct packed {
    logic [RAS_PTR_WIDTH-1:0] tos;
    logic [RAS_PTR_WIDTH:0]   count;
    logic [XLEN-1:0]          top;
  } ras_ckpt_t;

endpackage

`default_nettype wire

// File: rtl/ras_ckpt_queue.sv
// ============================================================================
// ras_ckpt_queue : in-order checkpoint FIFO with rollback to any live slot
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ras_ckpt_queue #(
  parameter int NUM_CKPT = 4,
  parameter int DW       = 8,
  parameter int IDW      = $clog2(NUM_CKPT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ckpt_req_i,
  input  logic [DW-1:0]  ckpt_data_i,
  output logic           ckpt_ack_o,
  output logic [IDW-1:0] ckpt_id_o,
  output logic           ckpt_full_o,
  input  logic           ckpt_release_i,
  input  logic           restore_i,
  input  logic [IDW-1:0] restore_id_i,
  output logic           restore_ok_o,
  output logic [DW-1:0]  restore_data_o,
  output logic           restore_err_o
);

  localparam logic [IDW:0] OCC_FULL = (IDW+1)'(NUM_CKPT);

  logic [IDW-1:0] head_q, head_d;
  logic [IDW-1:0] tail_q, tail_d;
  logic [IDW:0]   occ_q, occ_d;
  logic           restore_err_q;
  logic [DW-1:0]  slot_q [NUM_CKPT];

  logic [IDW-1:0] offset;
  logic           in_range;
  logic           rel_ok;

  // Age of the requested slot relative to the oldest live one.
  assign offset   = restore_id_i - head_q;
  assign in_range = ({1'b0, offset} < occ_q);
  assign rel_ok   = ckpt_release_i & (occ_q != '0);

  assign ckpt_full_o    = (occ_q == OCC_FULL);
  assign ckpt_ack_o     = ckpt_req_i & ~ckpt_full_o & ~restore_i;
  assign ckpt_id_o      = tail_q;
  assign restore_ok_o   = restore_i & in_range;
  assign restore_data_o = slot_q[restore_id_i];
  assign restore_err_o  = restore_err_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (restore_i) begin
      if (in_range) begin
        tail_d = restore_id_i;
        occ_d  = {1'b0, offset};
        // Releasing the restored slot itself just empties the queue in place.
        if (ckpt_release_i && (offset != '0)) begin
          head_d = head_q + 1'b1;
          occ_d  = {1'b0, offset} - 1'b1;
        end
      end
    end else begin
      if (ckpt_ack_o) tail_d = tail_q + 1'b1;
      if (rel_ok)     head_d = head_q + 1'b1;
      occ_d = occ_q + {{IDW{1'b0}}, ckpt_ack_o} - {{IDW{1'b0}}, rel_ok};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      restore_err_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
      restore_err_q <= restore_i & ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (ckpt_ack_o) slot_q[tail_q] <= ckpt_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/spec_ras.sv
// ============================================================================
// spec_ras : circular return address stack with speculative checkpointing
// Revision : 1.0
// ============================================================================
`default_nettype none

module spec_ras #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int DEPTH    = riscv_pkg::RAS_SIZE,
  parameter int NUM_CKPT = riscv_pkg::RAS_NUM_CKPT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [XLEN-1:0]             push_addr,
  input  logic                        pop,
  output logic [XLEN-1:0]             predicted_return,
  output logic                        valid,
  input  logic                        ckpt_req,
  output logic                        ckpt_ack,
  output logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
  output logic                        ckpt_full,
  input  logic                        ckpt_release,
  input  logic                        restore,
  input  logic [$clog2(NUM_CKPT)-1:0] restore_id,
  output logic                        restore_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_CKPT);
  localparam int DW = PW + CW + XLEN;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [XLEN-1:0] stack_q [DEPTH];
  logic [PW-1:0]   tos_q, tos_d;
  logic [CW-1:0]   count_q, count_d;

  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] ckpt_top;
  logic [DW-1:0]   ckpt_data;
  logic [DW-1:0]   rest_data;
  logic            rest_ok;
  logic [PW-1:0]   rest_tos;
  logic [CW-1:0]   rest_cnt;
  logic [XLEN-1:0] rest_top;

  assign rest_tos = rest_data[DW-1 -: PW];
  assign rest_cnt = rest_data[XLEN +: CW];
  assign rest_top = rest_data[XLEN-1:0];

  assign valid            = (count_q != '0);
  assign predicted_return = valid ? stack_q[tos_q] : '0;

  // Single stack write port shared by push, replace-top and restore.
  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = push_addr;
    if (restore) begin
      if (rest_ok) begin
        tos_d   = rest_tos;
        count_d = rest_cnt;
        wr_en   = 1'b1;
        wr_idx  = rest_tos;
        wr_data = rest_top;
      end
    end else if (push && (!pop || (count_q == '0))) begin
      tos_d   = tos_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = tos_q + 1'b1;
      count_d = (count_q == CNT_FULL) ? count_q : count_q + 1'b1;
    end else if (push && pop) begin
      wr_en = 1'b1;
    end else if (pop && (count_q != '0)) begin
      tos_d   = tos_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // Snapshot reflects this cycle's update, including a write to the new top.
  assign ckpt_top  = (wr_en && (wr_idx == tos_d)) ? wr_data : stack_q[tos_d];
  assign ckpt_data = {tos_d, count_d, ckpt_top};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q   <= '0;
      count_q <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) stack_q[wr_idx] <= wr_data;
  end

  ras_ckpt_queue #(
    .NUM_CKPT (NUM_CKPT),
    .DW       (DW),
    .IDW      (IW)
  ) u_ckpt_queue (
    .clk            (clk),
    .reset          (reset),
    .ckpt_req_i     (ckpt_req),
    .ckpt_data_i    (ckpt_data),
    .ckpt_ack_o     (ckpt_ack),
    .ckpt_id_o      (ckpt_id),
    .ckpt_full_o    (ckpt_full),
    .ckpt_release_i (ckpt_release),
    .restore_i      (restore),
    .restore_id_i   (restore_id),
    .restore_ok_o   (rest_ok),
    .restore_data_o (rest_data),
    .restore_err_o  (restore_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_spec_ras.sv
// ============================================================================
// tb_spec_ras : scoreboard bench for spec_ras (default parameters)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spec_ras;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic [31:0] push_addr = '0;
  logic        pop = 1'b0;
  logic [31:0] predicted_return;
  logic        valid;
  logic        ckpt_req = 1'b0;
  logic        ckpt_ack;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        ckpt_release = 1'b0;
  logic        restore = 1'b0;
  logic [1:0]  restore_id = '0;
  logic        restore_err;

  always #5 clk = ~clk;

  spec_ras dut (
    .clk              (clk),
    .reset            (reset),
    .push             (push),
    .push_addr        (push_addr),
    .pop              (pop),
    .predicted_return (predicted_return),
    .valid            (valid),
    .ckpt_req         (ckpt_req),
    .ckpt_ack         (ckpt_ack),
    .ckpt_id          (ckpt_id),
    .ckpt_full        (ckpt_full),
    .ckpt_release     (ckpt_release),
    .restore          (restore),
    .restore_id       (restore_id),
    .restore_err      (restore_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [31:0] m_stk [8];
  int          m_tos, m_cnt, m_head, m_tail, m_occ;
  int          ck_tos [4];
  int          ck_cnt [4];
  logic [31:0] ck_top [4];
  bit          m_err;

  typedef struct {
    string       tag;
    logic [31:0] ret;
    bit          v;
    bit          full;
    bit          err;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    m_tos = 0; m_cnt = 0; m_head = 0; m_tail = 0; m_occ = 0; m_err = 0;
  endtask

  task automatic step(input bit p, input logic [31:0] a, input bit o, input bit cr,
                      input bit rel, input bit rs, input int rid, input string tag);
    exp_t e;
    bit   exp_ack;
    bit   rel_ok;
    int   off;
    @(negedge clk);
    push = p; push_addr = a; pop = o; ckpt_req = cr;
    ckpt_release = rel; restore = rs; restore_id = rid[1:0];
    #1;
    exp_ack = cr && (m_occ != 4) && !rs;
    check_val({tag, ".ack"}, {63'd0, ckpt_ack}, {63'd0, exp_ack});
    if (exp_ack) check_val({tag, ".id"}, {62'd0, ckpt_id}, 64'(m_tail));
    if (rs) begin
      off = (rid - m_head + 4) % 4;
      if (off < m_occ) begin
        m_tos = ck_tos[rid];
        m_cnt = ck_cnt[rid];
        m_stk[m_tos] = ck_top[rid];
        m_tail = rid;
        if (rel && off > 0) begin
          m_head = (m_head + 1) % 4;
          m_occ  = off - 1;
        end else if (rel) begin
          m_occ = 0;
        end else begin
          m_occ = off;
        end
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      m_err = 0;
      if (p && (!o || m_cnt == 0)) begin
        m_tos = (m_tos + 1) % 8;
        m_stk[m_tos] = a;
        if (m_cnt < 8) m_cnt++;
      end else if (p && o) begin
        m_stk[m_tos] = a;
      end else if (o && m_cnt > 0) begin
        m_tos = (m_tos + 7) % 8;
        m_cnt--;
      end
      rel_ok = rel && (m_occ > 0);
      if (exp_ack) begin
        ck_tos[m_tail] = m_tos;
        ck_cnt[m_tail] = m_cnt;
        ck_top[m_tail] = m_stk[m_tos];
        m_tail = (m_tail + 1) % 4;
        m_occ++;
      end
      if (rel_ok) begin
        m_head = (m_head + 1) % 4;
        m_occ--;
      end
    end
    e.tag  = tag;
    e.ret  = (m_cnt != 0) ? m_stk[m_tos] : 32'd0;
    e.v    = (m_cnt != 0);
    e.full = (m_occ == 4);
    e.err  = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val({e.tag, ".ret"},  {32'd0, predicted_return}, {32'd0, e.ret});
    check_val({e.tag, ".vld"},  {63'd0, valid},            {63'd0, e.v});
    check_val({e.tag, ".full"}, {63'd0, ckpt_full},        {63'd0, e.full});
    check_val({e.tag, ".err"},  {63'd0, restore_err},      {63'd0, e.err});
  endtask

  // Reset is raised between edges and its effect checked before the next edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    push = 0; pop = 0; ckpt_req = 0; ckpt_release = 0; restore = 0;
    reset = 1'b1;
    #1;
    check_val({tag, ".vld"},  {63'd0, valid},            64'd0);
    check_val({tag, ".ret"},  {32'd0, predicted_return}, 64'd0);
    check_val({tag, ".full"}, {63'd0, ckpt_full},        64'd0);
    check_val({tag, ".id"},   {62'd0, ckpt_id},          64'd0);
    check_val({tag, ".ack"},  {63'd0, ckpt_ack},         64'd0);
    check_val({tag, ".err"},  {63'd0, restore_err},      64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("rst0");

    // Basic push/pop
    step(1, 32'h100, 0, 0, 0, 0, 0, "p100");
    step(1, 32'h200, 0, 0, 0, 0, 0, "p200");
    step(1, 32'h300, 0, 0, 0, 0, 0, "p300");
    check_val("b.top300", {32'd0, predicted_return}, 64'h300);
    step(0, 0, 1, 0, 0, 0, 0, "pop1");
    check_val("b.top200", {32'd0, predicted_return}, 64'h200);
    check_val("b.valid", {63'd0, valid}, 64'd1);
    step(0, 0, 1, 0, 0, 0, 0, "pop2");
    step(0, 0, 1, 0, 0, 0, 0, "pop3");
    step(0, 0, 1, 0, 0, 0, 0, "popE");

    // Overflow: nine pushes into eight entries, then drain
    for (int i = 1; i <= 9; i++) step(1, 32'(i * 16), 0, 0, 0, 0, 0, "ovf.push");
    check_val("ovf.top", {32'd0, predicted_return}, 64'h90);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0, 0, "ovf.pop");
    check_val("ovf.empty", {63'd0, valid}, 64'd0);
    step(0, 0, 1, 0, 0, 0, 0, "ovf.extra");
    check_val("ovf.ret0", {32'd0, predicted_return}, 64'd0);
    check_val("ovf.vld0", {63'd0, valid}, 64'd0);

    // Checkpoint then overwrite, then roll back
    step(1, 32'hA0, 0, 0, 0, 0, 0, "rb.push");
    step(0, 0, 0, 1, 0, 0, 0, "rb.ckpt");
    step(0, 0, 1, 0, 0, 0, 0, "rb.pop");
    step(1, 32'hB0, 0, 0, 0, 0, 0, "rb.pushB");
    step(0, 0, 0, 0, 0, 1, 0, "rb.rest");
    check_val("rb.retA0", {32'd0, predicted_return}, 64'hA0);
    check_val("rb.id0", {62'd0, ckpt_id}, 64'd0);

    // Fill the checkpoint queue
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, "fq.ckpt");
    check_val("fq.full", {63'd0, ckpt_full}, 64'd1);
    step(0, 0, 0, 1, 0, 0, 0, "fq.fifth");
    step(0, 0, 0, 0, 1, 0, 0, "fq.rel");
    check_val("fq.notfull", {63'd0, ckpt_full}, 64'd0);
    check_val("fq.nextid", {62'd0, ckpt_id}, 64'd0);
    step(0, 0, 0, 1, 0, 0, 0, "fq.again");

    // Selective rollback and invalid id
    do_reset("rst1");
    step(1, 32'h1, 0, 1, 0, 0, 0, "sr.c0");
    step(1, 32'h2, 0, 1, 0, 0, 0, "sr.c1");
    step(1, 32'h3, 0, 1, 0, 0, 0, "sr.c2");
    step(0, 0, 0, 0, 0, 1, 1, "sr.rest1");
    check_val("sr.ret2", {32'd0, predicted_return}, 64'h2);
    check_val("sr.nextid1", {62'd0, ckpt_id}, 64'd1);
    step(0, 0, 0, 1, 0, 0, 0, "sr.c1b");
    step(1, 32'h55, 1, 0, 0, 1, 3, "sr.bad");
    check_val("sr.errpulse", {63'd0, restore_err}, 64'd1);
    check_val("sr.unchanged", {32'd0, predicted_return}, 64'h2);
    step(0, 0, 0, 0, 0, 0, 0, "sr.idle");
    // Restore of the head slot combined with its release
    step(0, 0, 0, 0, 1, 1, 0, "sr.relhead");
    check_val("sr.id0", {62'd0, ckpt_id}, 64'd0);
    step(1, 32'h77, 0, 1, 0, 0, 0, "sr.c0b");
    step(1, 32'h88, 0, 1, 0, 0, 0, "sr.c1c");
    step(0, 0, 0, 0, 1, 1, 1, "sr.relrest");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), "rnd");
    end

    // Asynchronous reset mid-operation
    do_reset("rst2");
    step(1, 32'h11, 0, 0, 0, 0, 0, "ar.p1");
    step(1, 32'h22, 0, 1, 0, 0, 0, "ar.p2");
    step(1, 32'h33, 0, 1, 0, 0, 0, "ar.p3");
    do_reset("rst3");
    step(1, 32'h44, 0, 1, 0, 0, 0, "ar.after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
